// File: rtl/change_dispenser.sv
// Greedy coin payout (200/100/50/20/10) over a valid/ack hopper handshake.
// Optional per-denomination stock counters are built when COIN_STOCK_EN is defined.
module change_dispenser #(
    parameter int AMOUNT_W    = 16,
    parameter int ACK_TIMEOUT = 50,
    parameter int STOCK_W     = 8,
    parameter int STOCK_INIT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AMOUNT_W-1:0] change_in,
    input  logic                change_valid,
    input  logic                coin_ack,
    input  logic                refill,
    output logic [AMOUNT_W-1:0] coin_out,
    output logic                coin_valid,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [AMOUNT_W-1:0] remaining_out
);

    localparam int TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [2:0] NO_DENOM = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EJECT  = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [AMOUNT_W-1:0] rem;
    logic [TIMER_W-1:0]  timer;
    logic [4:0]          avail;
    logic [2:0]          sel_idx;

    // Index 0 is the largest denomination.
    function automatic logic [AMOUNT_W-1:0] denom_value(input logic [2:0] idx);
        case (idx)
            3'd0:    return AMOUNT_W'(200);
            3'd1:    return AMOUNT_W'(100);
            3'd2:    return AMOUNT_W'(50);
            3'd3:    return AMOUNT_W'(20);
            3'd4:    return AMOUNT_W'(10);
            default: return {AMOUNT_W{1'b0}};
        endcase
    endfunction

    // Scanning smallest to largest leaves the largest fitting, available coin.
    function automatic logic [2:0] pick_denom(input logic [AMOUNT_W-1:0] amount,
                                              input logic [4:0]          ok);
        logic [2:0] idx;
        idx = NO_DENOM;
        for (int i = 4; i >= 0; i--) begin
            if (ok[i] && (denom_value(3'(i)) <= amount)) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

`ifdef COIN_STOCK_EN
    logic [2:0]               cur_idx;
    logic [4:0][STOCK_W-1:0]  stock;

    // Stock counters; a refill overrides a same-cycle decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_idx <= 3'd0;
            stock   <= {5{STOCK_W'(STOCK_INIT)}};
        end else begin
            if (state == S_SELECT) begin
                cur_idx <= sel_idx;
            end else begin
                cur_idx <= cur_idx;
            end
            if (refill) begin
                stock <= {5{STOCK_W'(STOCK_INIT)}};
            end else if ((state == S_EJECT) && coin_ack) begin
                stock[cur_idx] <= stock[cur_idx] - STOCK_W'(1);
            end else begin
                stock <= stock;
            end
        end
    end

    // A denomination is selectable only while it has coins left.
    always_comb begin
        avail = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            avail[i] = (stock[i] != {STOCK_W{1'b0}});
        end
    end
`else
    logic unused_refill;

    // Unlimited stock: every denomination is always selectable.
    always_comb begin
        avail = 5'b11111;
    end
    assign unused_refill = refill;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an ack in the timeout cycle still counts the coin.
    always_comb begin
        state_next = state;
        sel_idx    = pick_denom(rem, avail);
        case (state)
            S_IDLE: begin
                if (change_valid) begin
                    state_next = S_SELECT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_SELECT: begin
                if (rem == {AMOUNT_W{1'b0}}) begin
                    state_next = S_DONE;
                end else if (sel_idx != NO_DENOM) begin
                    state_next = S_EJECT;
                end else begin
                    state_next = S_ERR;
                end
            end
            S_EJECT: begin
                if (coin_ack) begin
                    state_next = S_SELECT;
                end else if (timer == TIMER_LAST) begin
                    state_next = S_ERR;
                end else begin
                    state_next = S_EJECT;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem           <= {AMOUNT_W{1'b0}};
            timer         <= {TIMER_W{1'b0}};
            coin_out      <= {AMOUNT_W{1'b0}};
            coin_valid    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            remaining_out <= {AMOUNT_W{1'b0}};
        end else begin
            busy  <= (state_next != S_IDLE);
            done  <= (state == S_DONE);
            error <= (state == S_ERR);
            case (state)
                S_IDLE: begin
                    if (change_valid) begin
                        rem           <= change_in;
                        remaining_out <= {AMOUNT_W{1'b0}};
                    end else begin
                        rem <= rem;
                    end
                end
                S_SELECT: begin
                    if ((rem != {AMOUNT_W{1'b0}}) && (sel_idx != NO_DENOM)) begin
                        coin_out   <= denom_value(sel_idx);
                        coin_valid <= 1'b1;
                        timer      <= {TIMER_W{1'b0}};
                    end else begin
                        coin_valid <= 1'b0;
                    end
                end
                S_EJECT: begin
                    if (coin_ack) begin
                        rem        <= rem - coin_out;
                        coin_out   <= {AMOUNT_W{1'b0}};
                        coin_valid <= 1'b0;
                    end else if (timer == TIMER_LAST) begin
                        coin_out   <= {AMOUNT_W{1'b0}};
                        coin_valid <= 1'b0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                S_ERR: begin
                    remaining_out <= rem;
                end
                default: begin
                    coin_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected coins/events,
// a negedge monitor acks coins and checks them along with done/error pulses.
module tb_change_dispenser;

    localparam int AW = 16;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] change_in = '0;
    logic          change_valid = 1'b0;
    logic          coin_ack = 1'b0;
    logic          refill = 1'b0;
    logic [AW-1:0] coin_out;
    logic          coin_valid;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] remaining_out;

    typedef struct {
        bit is_err;
        int rem;
    } ev_t;

    int  exp_coins[$];
    ev_t exp_ev[$];
    int  ack_budget = 1000;
    int  checks = 0;
    int  errors = 0;

    change_dispenser #(.AMOUNT_W(AW), .ACK_TIMEOUT(TO), .STOCK_W(8), .STOCK_INIT(8)) dut (
        .clk(clk), .rst(rst), .change_in(change_in), .change_valid(change_valid),
        .coin_ack(coin_ack), .refill(refill), .coin_out(coin_out), .coin_valid(coin_valid),
        .busy(busy), .done(done), .error(error), .remaining_out(remaining_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input bit is_err, input int rem);
        ev_t e;
        e.is_err = is_err;
        e.rem    = rem;
        exp_ev.push_back(e);
    endtask

    // Monitor: acknowledges presented coins (within budget) and checks them and result pulses.
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            coin_ack = 1'b0;
        end else begin
            if (coin_valid && !coin_ack && ack_budget > 0) begin
                if (exp_coins.size() == 0) chk("coin_unexpected", int'(coin_out), -1);
                else chk("coin_value", int'(coin_out), exp_coins.pop_front());
                coin_ack = 1'b1;
                ack_budget--;
            end else begin
                coin_ack = 1'b0;
            end
            if (!coin_valid) chk("coin_out_idle_zero", int'(coin_out), 0);
            if (done || error) begin
                if (exp_ev.size() == 0) begin
                    chk("event_unexpected", done ? 1 : 2, 0);
                end else begin
                    e = exp_ev.pop_front();
                    chk("event_is_error", int'(error), int'(e.is_err));
                    chk("event_done", int'(done), e.is_err ? 0 : 1);
                    chk("remaining_out", int'(remaining_out), e.rem);
                end
            end
        end
    end

    // Issue one request and wait (bounded) for its done/error pulse.
    task automatic run_req(input int amount, input int max_cyc, output int cyc, output int vcyc);
        @(negedge clk);
        change_in    = AW'(amount);
        change_valid = 1'b1;
        @(posedge clk);
        #1;
        change_valid = 1'b0;
        cyc  = 0;
        vcyc = 0;
        while (cyc < max_cyc && !(done || error)) begin
            @(posedge clk);
            #1;
            cyc++;
            if (coin_valid) vcyc++;
        end
        if (!(done || error)) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no done/error expected pulse within %0d cycles", max_cyc);
        end
    endtask

    task automatic drain(input int amount, input int denom, input int n);
        int c, v;
        for (int i = 0; i < n; i++) exp_coins.push_back(denom);
        push_ev(1'b0, 0);
        run_req(amount, 300, c, v);
    endtask

    initial begin
        int cyc, vcyc;
        #1;
        chk("reset_coin_valid", int'(coin_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done_error", int'({done, error}), 0);
        chk("reset_remaining", int'(remaining_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 70 with immediate acks -> 50,20 and done six cycles later
        exp_coins.push_back(50);
        exp_coins.push_back(20);
        push_ev(1'b0, 0);
        run_req(70, 20, cyc, vcyc);
        chk("t1_latency", cyc, 6);
        chk("t1_busy_after", int'(busy), 0);

        // zero -> no coin, done two cycles after the request
        push_ev(1'b0, 0);
        run_req(0, 20, cyc, vcyc);
        chk("t2_latency", cyc, 2);
        chk("t2_no_coin", vcyc, 0);

        // 25 -> coin 20 then error with 5 left, held afterwards
        exp_coins.push_back(20);
        push_ev(1'b1, 5);
        run_req(25, 20, cyc, vcyc);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_remaining_held", int'(remaining_out), 5);

        // 10 never acked -> coin valid for TO cycles, then error with 10 left
        ack_budget = 0;
        push_ev(1'b1, 10);
        run_req(10, 200, cyc, vcyc);
        chk("t4_valid_cycles", vcyc, TO);
        chk("t4_latency", cyc, TO + 2);
        ack_budget = 1000;

        // remaining_out clears on the next accepted request
        exp_coins.push_back(200);
        push_ev(1'b0, 0);
        run_req(200, 20, cyc, vcyc);

        // reset while coin 100 of 300 is presented
        ack_budget = 1;
        exp_coins.push_back(200);
        @(negedge clk);
        change_in    = AW'(300);
        change_valid = 1'b1;
        @(posedge clk);
        #1;
        change_valid = 1'b0;
        cyc = 0;
        while (cyc < 30 && !(coin_valid && coin_out == AW'(100))) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t5_coin100_presented", int'(coin_out), 100);
        rst = 1'b1;
        #1;
        chk("t5_async_coin_valid", int'(coin_valid), 0);
        chk("t5_async_coin_out", int'(coin_out), 0);
        chk("t5_async_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ack_budget = 1000;
        exp_coins.push_back(20);
        exp_coins.push_back(10);
        push_ev(1'b0, 0);
        run_req(30, 20, cyc, vcyc);

        // request while busy is dropped
        exp_coins.push_back(20);
        push_ev(1'b0, 0);
        @(negedge clk);
        change_in    = AW'(20);
        change_valid = 1'b1;
        @(negedge clk);
        change_in = AW'(50);
        repeat (3) @(negedge clk);
        change_valid = 1'b0;
        cyc = 0;
        while (cyc < 20 && !(done || error)) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk("t7_dropped_busy", int'(busy), 0);

`ifdef COIN_STOCK_EN
        drain(1600, 200, 8);
        drain(800, 100, 8);
        drain(400, 50, 8);
        drain(100, 20, 5);
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        drain(100, 100, 1);
`endif

        repeat (3) @(negedge clk);
        chk("coin_queue_empty", exp_coins.size(), 0);
        chk("event_queue_empty", exp_ev.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected end of test");
        $fatal(1, "bench timeout");
    end

endmodule
